// File: rtl/bcd_scan_display.sv
// bcd_scan_display: scans three snapshotted BCD digits onto a 4-digit
// common-anode 7-segment display, with leading-zero blanking, dead time
// between slots and a one-cycle frame strobe.
// Optional feature macro: SEG_BLINK_EN (frame-counted display blinking).
module bcd_scan_display #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEAD_CYC        = 4,
  parameter int LEAD_ZERO_BLANK = 1,
  parameter int BLINK_FRAMES    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hund,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_TENS = 2'd1,
    S_HUND = 2'd2
  } slot_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low glyph for one BCD code; anything above 9 shows a dash.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = SEG_DASH;
    endcase
  endfunction

  logic [CW-1:0] r_div_cnt;
  slot_t         r_slot;
  slot_t         w_slot_nxt;
  logic [3:0]    r_snap_h;
  logic [3:0]    r_snap_t;
  logic [3:0]    r_snap_o;
  logic          r_frame_tick;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_tick;
  logic          w_snap_edge;
  logic          w_dead;
  logic          w_dark;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;

  assign w_tick      = (r_div_cnt == CW'(SCAN_DIV - 1));
  assign w_snap_edge = w_tick && (r_slot == S_HUND);
  assign w_dead      = (32'(r_div_cnt) < DEAD_CYC);

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 0) ? $clog2(2 * BLINK_FRAMES) : 1;

  logic [FW-1:0] r_frame_cnt;

  // Frame counter advances once per snapshot and wraps after two blink half-periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_snap_edge) begin
      if (r_frame_cnt == FW'(2 * BLINK_FRAMES - 1)) r_frame_cnt <= '0;
      else                                          r_frame_cnt <= r_frame_cnt + FW'(1);
    end
  end

  assign w_dark = blink && (r_frame_cnt >= FW'(BLINK_FRAMES));
`else
  logic w_unused_blink;
  assign w_unused_blink = blink;
  assign w_dark         = 1'b0;
`endif

  // Slot timer: free-running 0..SCAN_DIV-1, restarted by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + CW'(1);
  end

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_slot <= S_ONES;
    else        r_slot <= w_slot_nxt;
  end

  // Scan FSM next state: rotate ones -> tens -> hundreds on each slot tick.
  always_comb begin
    w_slot_nxt = r_slot;
    if (w_tick) begin
      case (r_slot)
        S_ONES:  w_slot_nxt = S_TENS;
        S_TENS:  w_slot_nxt = S_HUND;
        default: w_slot_nxt = S_ONES;
      endcase
    end
  end

  // Snapshot the inputs once per frame so a changing value never tears mid-scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_h     <= 4'd0;
      r_snap_t     <= 4'd0;
      r_snap_o     <= 4'd0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_snap_edge;
      if (w_snap_edge) begin
        r_snap_h <= hund;
        r_snap_t <= tens;
        r_snap_o <= ones;
      end
    end
  end

  // Digit selection and leading-zero blanking; codes above 9 never count as zero.
  always_comb begin
    w_digit = r_snap_o;
    w_blank = 1'b0;
    case (r_slot)
      S_TENS: begin
        w_digit = r_snap_t;
        w_blank = (LEAD_ZERO_BLANK != 0) && (r_snap_h == 4'd0) && (r_snap_t == 4'd0);
      end
      S_HUND: begin
        w_digit = r_snap_h;
        w_blank = (LEAD_ZERO_BLANK != 0) && (r_snap_h == 4'd0);
      end
      default: begin
        w_digit = r_snap_o;
        w_blank = 1'b0;
      end
    endcase
  end

  // Next output values: dead time and blink darken everything; a blanked
  // digit keeps its anode on so every slot has the same duty cycle.
  always_comb begin
    w_an_nxt  = 4'hF;
    w_seg_nxt = SEG_BLANK;
    if (!w_dead && !w_dark) begin
      w_an_nxt  = ~(4'b0001 << r_slot);
      w_seg_nxt = w_blank ? SEG_BLANK : glyph(w_digit);
    end
  end

  // Registered display outputs (one clock behind the scan state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= 4'hF;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule
